// File: rtl/vga_mon_pkg.sv
// vga_mon_pkg: monitor state encoding, default 640x480 timing and derived raster geometry
package vga_mon_pkg;
    typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} vga_mon_state_t;
    localparam int DEF_PIX_DIV   = 2;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    function automatic int total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction
    function automatic int win_lo(input int sync, input int bp);
        return sync + bp;
    endfunction
    function automatic int win_hi(input int vis, input int sync, input int bp);
        return sync + bp + vis;
    endfunction
endpackage

// File: rtl/vga_mon_axis.sv
// vga_mon_axis: sync fall/rise detector with saturating position counter and width/period checks
module vga_mon_axis #(
    parameter int W        = 11,
    parameter int SYNC_LEN = 192,
    parameter int TOTAL    = 1600
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         i_en,
    input  logic         i_sync,
    output logic [W-1:0] o_cnt,
    output logic         o_fall,
    output logic         o_err_width,
    output logic         o_err_len
);
    localparam logic [W-1:0] L_SYNC = W'(SYNC_LEN);
    localparam logic [W-1:0] L_LAST = W'(TOTAL - 1);
    logic         r_q;
    logic [W-1:0] r_cnt;
    logic         w_rise;
    assign o_fall      = i_en && !i_sync && r_q;
    assign w_rise      = i_en && i_sync && !r_q;
    // o_cnt is the position of the current sample: 0 on the sync fall itself
    assign o_cnt       = o_fall ? '0 : (i_en && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    assign o_err_width = w_rise && o_cnt != L_SYNC;
    assign o_err_len   = o_fall && r_cnt != L_LAST;
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_q   <= 1'b1;
            r_cnt <= '0;
        end else begin
            if (i_en)
                r_q <= i_sync;
            r_cnt <= o_cnt;
        end
    end
endmodule

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: locks onto a VGA raster, checks sync timing and reports a lit-pixel count per clean frame
module vga_timing_monitor
    import vga_mon_pkg::*;
#(
    parameter int PIX_DIV   = DEF_PIX_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        vga_r,
    input  logic        vga_g,
    input  logic        vga_b,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic [18:0] lit_count,
    output logic        err_hsync_width,
    output logic        err_line_len,
    output logic        err_vsync_width,
    output logic        err_frame_len,
    output logic        err_blank_rgb
);
    localparam int H_TOTAL = total(H_VISIBLE, H_FP, H_SYNC, H_BP) * PIX_DIV;
    localparam int V_TOTAL = total(V_VISIBLE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LO = HW'(win_lo(H_SYNC, H_BP) * PIX_DIV);
    localparam logic [HW-1:0] H_HI = HW'(win_hi(H_VISIBLE, H_SYNC, H_BP) * PIX_DIV);
    localparam logic [VW-1:0] V_LO = VW'(win_lo(V_SYNC, V_BP));
    localparam logic [VW-1:0] V_HI = VW'(win_hi(V_VISIBLE, V_SYNC, V_BP));
    localparam logic [HW-1:0] PD   = HW'(PIX_DIV);
    vga_mon_state_t r_state;
    logic [18:0]    r_acc;
    logic [18:0]    r_lit;
    logic [15:0]    r_fc;
    logic           r_done;
    logic [4:0]     r_flags;
    logic [HW-1:0]  w_h_cnt;
    logic [VW-1:0]  w_v_cnt;
    logic           w_hs_fall;
    logic           w_vs_fall;
    logic           w_h_err_w;
    logic           w_h_err_l;
    logic           w_v_err_w;
    logic           w_v_err_l;
    logic           w_vis;
    logic           w_rgb;
    logic           w_pix;
    logic           w_active;
    logic           w_fail;
    logic           w_done;
    logic [4:0]     w_errs;
    vga_mon_axis #(.W(HW), .SYNC_LEN(H_SYNC * PIX_DIV), .TOTAL(H_TOTAL)) u_h (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_en       (1'b1),
        .i_sync     (vga_hsync),
        .o_cnt      (w_h_cnt),
        .o_fall     (w_hs_fall),
        .o_err_width(w_h_err_w),
        .o_err_len  (w_h_err_l)
    );
    // the vertical axis only moves on line boundaries
    vga_mon_axis #(.W(VW), .SYNC_LEN(V_SYNC), .TOTAL(V_TOTAL)) u_v (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_en       (w_hs_fall),
        .i_sync     (vga_vsync),
        .o_cnt      (w_v_cnt),
        .o_fall     (w_vs_fall),
        .o_err_width(w_v_err_w),
        .o_err_len  (w_v_err_l)
    );
    assign w_vis    = w_h_cnt >= H_LO && w_h_cnt < H_HI && w_v_cnt >= V_LO && w_v_cnt < V_HI;
    assign w_rgb    = vga_r | vga_g | vga_b;
    assign w_pix    = w_vis && w_rgb && (w_h_cnt % PD) == '0;
    assign w_active = r_state != SEARCH;
    assign w_errs   = {w_h_err_w, w_h_err_l, w_v_err_w, w_v_err_l, !w_vis && w_rgb} & {5{w_active}};
    assign w_fail   = |w_errs;
    assign w_done   = w_active && w_vs_fall && !w_fail;
    assign locked      = r_state == LOCKED;
    assign frame_done  = r_done;
    assign frame_count = r_fc;
    assign lit_count   = r_lit;
    assign {err_hsync_width, err_line_len, err_vsync_width, err_frame_len, err_blank_rgb} = r_flags;
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= SEARCH;
            r_acc   <= '0;
            r_lit   <= '0;
            r_fc    <= '0;
            r_done  <= 1'b0;
            r_flags <= '0;
        end else begin
            r_state <= w_fail ? SEARCH : !w_vs_fall ? r_state : w_active ? LOCKED : LOCKING;
            r_flags <= r_flags | (r_state == LOCKED ? w_errs : 5'b0);
            r_done  <= w_done;
            r_acc   <= (w_vs_fall || !w_active) ? '0 : r_acc + 19'(w_pix);
            if (w_done) begin
                r_lit <= r_acc;
                r_fc  <= r_fc + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: drives scaled-down rasters frame by frame and checks lock, signatures and flags
module tb_vga_timing_monitor;
    localparam int PD = 2, HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 8, VF = 2, VS = 2, VB = 3;
    localparam int HT  = (HV + HF + HS + HB) * PD;
    localparam int VT  = VV + VF + VS + VB;
    localparam int HLO = (HS + HB) * PD;
    localparam int HHI = (HS + HB + HV) * PD;
    localparam int VLO = VS + VB;
    localparam int VHI = VS + VB + VV;
    // pat: 0 black 1 white 2 checker 3 single red 4 random
    // fault: 0 none 1 short hsync 2 blank glitch 3 short frame 4 long line 5 long vsync
    typedef struct {
        int pat;
        int fault;
        int lck;
        int done;
        int fc;
        int lit;
        int flags;
    } vec_t;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        vga_r = 1'b0, vga_g = 1'b0, vga_b = 1'b0;
    logic        vga_hsync = 1'b1, vga_vsync = 1'b1;
    logic        locked, frame_done;
    logic [15:0] frame_count;
    logic [18:0] lit_count;
    logic        e_hw, e_ll, e_vw, e_fl, e_bl;
    logic [2:0]  img [VV][HV];
    vec_t        tbl [19];
    int vectors = 0, miscompares = 0, pulses = 0;
    int ms, m_fc, m_lit, m_flags, m_done, m_pulses = 0, prev_lit;
    bit prev_short;
    always #5 clk = ~clk;
    vga_timing_monitor #(
        .PIX_DIV(PD), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .n_rst(n_rst), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .locked(locked), .frame_done(frame_done),
        .frame_count(frame_count), .lit_count(lit_count), .err_hsync_width(e_hw),
        .err_line_len(e_ll), .err_vsync_width(e_vw), .err_frame_len(e_fl), .err_blank_rgb(e_bl)
    );
    always @(negedge clk) if (frame_done) pulses++;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, "_locked"}, locked, v.lck);
        chk({tag, "_frame_done"}, frame_done, v.done);
        chk({tag, "_frame_count"}, frame_count, v.fc);
        chk({tag, "_lit_count"}, lit_count, v.lit);
        chk({tag, "_flags"}, int'({e_hw, e_ll, e_vw, e_fl, e_bl}), v.flags);
    endtask
    function automatic int fill(input int pat);
        int n = 0;
        for (int y = 0; y < VV; y++)
            for (int x = 0; x < HV; x++) begin
                img[y][x] = pat == 1 ? 3'b111 : pat == 2 ? ((x + y) % 2 == 0 ? 3'b111 : 3'b000) :
                            pat == 3 ? ((x == 0 && y == 0) ? 3'b100 : 3'b000) :
                            pat == 4 ? 3'($urandom) : 3'b000;
                n += (img[y][x] != 3'b000) ? 1 : 0;
            end
        return n;
    endfunction
    task automatic model_reset();
        ms = 0;
        m_fc = 0;
        m_lit = 0;
        m_flags = 0;
        m_done = 0;
        prev_lit = 0;
        prev_short = 0;
    endtask
    task automatic model_boundary();
        m_done = 0;
        if (ms != 0 && prev_short) begin
            if (ms == 2) m_flags |= 2;
            ms = 0;
        end else if (ms == 0) begin
            ms = 1;
        end else begin
            ms = 2;
            m_done = 1;
            m_pulses++;
            m_fc = (m_fc + 1) % 65536;
            m_lit = prev_lit;
        end
    endtask
    task automatic model_frame_end(input int fault, input int lit);
        if (ms != 0 && fault != 0 && fault != 3) begin
            if (ms == 2) m_flags |= fault == 1 ? 16 : fault == 2 ? 1 : fault == 4 ? 8 : 4;
            ms = 0;
        end
        prev_short = fault == 3;
        prev_lit = lit;
    endtask
    task automatic run_frame(input vec_t v, input int stop, output int lit);
        int nl;
        int last;
        int hs_len;
        logic [2:0] px;
        nl = v.fault == 3 ? VT - 1 : VT;
        last = stop >= 0 ? stop : nl;
        hs_len = HS * PD;
        lit = fill(v.pat);
        for (int l = 0; l < last; l++) begin
            for (int c = 0; c < ((v.fault == 4 && l == 3) ? HT + 1 : HT); c++) begin
                px = 3'b000;
                if (c >= HLO && c < HHI && l >= VLO && l < VHI)
                    px = (v.pat == 4 && c % PD != 0) ? 3'($urandom) : img[l - VLO][(c - HLO) / PD];
                if (v.fault == 2 && l == VLO + 1 && c == HHI + 2)
                    px = 3'b010;
                {vga_r, vga_g, vga_b} = px;
                vga_hsync = c >= ((v.fault == 1 && l == VLO + 1) ? hs_len - 2 : hs_len);
                vga_vsync = l >= (v.fault == 5 ? VS + 1 : VS);
                tick();
                if (l == 0 && c == 0)
                    chk_all($sformatf("frame_start_p%0d_f%0d", v.pat, v.fault), v);
                if (v.fault == 1 && l == VLO + 1 && c == hs_len - 3)
                    chk("hs_pre_locked", locked, ms == 2 ? 1 : 0);
                if (v.fault == 1 && l == VLO + 1 && c == hs_len - 2) begin
                    chk("hs_err_unlock", locked, 0);
                    chk("hs_err_flag", e_hw, (ms == 2 || (m_flags & 16) != 0) ? 1 : 0);
                end
            end
        end
    endtask
    task automatic step(input int pat, input int fault, input int stop);
        vec_t v;
        int lit;
        model_boundary();
        v = '{pat, fault, ms == 2 ? 1 : 0, m_done, m_fc, m_lit, m_flags};
        run_frame(v, stop, lit);
        model_frame_end(fault, lit);
    endtask
    initial begin
        vec_t zero;
        int lit;
        zero = '{default: 0};
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 1, 1, 0, 0};
        tbl[2]  = '{1, 0, 1, 1, 2, 0, 0};
        tbl[3]  = '{2, 0, 1, 1, 3, 128, 0};
        tbl[4]  = '{3, 0, 1, 1, 4, 64, 0};
        tbl[5]  = '{0, 1, 1, 1, 5, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 5, 1, 16};
        tbl[7]  = '{0, 0, 1, 1, 6, 0, 16};
        tbl[8]  = '{0, 2, 1, 1, 7, 0, 16};
        tbl[9]  = '{0, 0, 0, 0, 7, 0, 17};
        tbl[10] = '{1, 0, 1, 1, 8, 0, 17};
        tbl[11] = '{0, 3, 1, 1, 9, 128, 17};
        tbl[12] = '{0, 0, 0, 0, 9, 128, 19};
        tbl[13] = '{0, 0, 0, 0, 9, 128, 19};
        tbl[14] = '{0, 4, 1, 1, 10, 0, 19};
        tbl[15] = '{0, 0, 0, 0, 10, 0, 27};
        tbl[16] = '{0, 0, 1, 1, 11, 0, 27};
        tbl[17] = '{0, 5, 1, 1, 12, 0, 27};
        tbl[18] = '{0, 0, 0, 0, 12, 0, 31};
        model_reset();
        for (int i = 0; i < 3; i++) begin
            {vga_r, vga_g, vga_b, vga_hsync, vga_vsync} = 5'($urandom);
            tick();
        end
        chk_all("reset", zero);
        n_rst = 1'b1;
        for (int i = 0; i < 19; i++) begin
            model_boundary();
            run_frame(tbl[i], -1, lit);
            model_frame_end(tbl[i].fault, lit);
        end
        step(1, 0, 7);
        n_rst = 1'b0;
        tick();
        chk_all("midreset", zero);
        n_rst = 1'b1;
        model_reset();
        for (int i = 0; i < 18; i++)
            step(i < 3 ? i % 2 : int'($urandom_range(0, 4)),
                 (i >= 3 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0, -1);
        chk("pulse_total", pulses, m_pulses);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
